// File: rtl/hacd_pkg.sv
// Shared Hawk/HACD types: ATT entry layout, status codes, lookup response, byteswap helper.
package hacd_pkg;

    localparam int          HACD_AXI4_ADDR_WIDTH = 64;
    localparam logic [63:0] HAWK_ATT_START       = 64'h0000_0000_1000_0000;
    localparam logic [63:0] HPPA_BASE_ADDR       = 64'h0000_0000_8000_0000;
    localparam int          ATT_ENTRY_CNT        = 65536;

    localparam logic [1:0] STS_DALLOC = 2'b00;
    localparam logic [1:0] STS_INCOMP = 2'b01;
    localparam logic [1:0] STS_COMP   = 2'b10;
    localparam logic [1:0] STS_ZERO   = 2'b11;

    typedef struct packed {
        logic [7:0]  zpd_cnt;
        logic [53:0] way;
        logic [1:0]  sts;
    } AttEntry;

    // ppa carries the full way field; the top trims it to its page-number width
    typedef struct packed {
        logic [53:0] ppa;
        logic [1:0]  sts;
        logic [7:0]  zpd_cnt;
        logic        allow;
        logic        err;
    } att_lkup_rsp_t;

    typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RESP} att_lkup_st_e;

    function automatic logic [63:0] get_8byte_byteswap(input logic [63:0] d);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b*8 +: 8] = d[(7-b)*8 +: 8];
        end
        return r;
    endfunction

    function automatic int clogb2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hawk_att_lkup_arb_rr.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer, pointer advances past the winner.
module hawk_rr_arb
    import hacd_pkg::*;
#(
    parameter  int N = 2,
    localparam int W = (N > 1) ? clogb2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] gnt_idx_o
);

    logic [W-1:0] r_ptr;
    int           w_c;
    logic         w_found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_c       = 0;
        for (int k = 0; k < N; k++) begin
            w_c = (int'(r_ptr) + k) % N;
            if (en_i && !w_found && req_i[w_c]) begin
                w_found       = 1'b1;
                gnt_o[w_c]    = 1'b1;
                gnt_idx_o     = W'(w_c);
            end
        end
    end

    if (N > 1) begin : g_ptr
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_ptr <= '0;
            end else if (w_found) begin
                r_ptr <= (gnt_idx_o == W'(N-1)) ? '0 : gnt_idx_o + 1'b1;
            end
        end
    end else begin : g_fixed
        logic w_unused_single;
        assign r_ptr           = '0;
        assign w_unused_single = clk_i ^ rst_ni;
    end

endmodule

// File: rtl/hawk_att_lkup_arb.sv
// Multi-channel ATT lookup: round-robin grant, one 64B AXI read per lookup, AttEntry decode, response to the winner.
module hawk_att_lkup_arb
    import hacd_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                ADDR_W      = HACD_AXI4_ADDR_WIDTH,
    parameter int                PN_W        = ADDR_W - 12,
    parameter logic [ADDR_W-1:0] ATT_BASE    = ADDR_W'(HAWK_ATT_START),
    parameter logic [ADDR_W-1:0] HPPA_BASE   = ADDR_W'(HPPA_BASE_ADDR),
    parameter int                ATT_ENTRIES = ATT_ENTRY_CNT,
    parameter int                BLK_BYTES   = 64,
    parameter int                ENTRY_BYTES = 8,
    parameter int                BYTESWAP    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_CH-1:0]      req_valid_i,
    input  logic [NUM_CH*PN_W-1:0] req_hppa_i,
    output logic [NUM_CH-1:0]      req_ready_o,
    output logic [NUM_CH-1:0]      resp_valid_o,
    input  logic [NUM_CH-1:0]      resp_ready_i,
    output logic [PN_W-1:0]        resp_ppa_o,
    output logic [1:0]             resp_sts_o,
    output logic [7:0]             resp_zpd_o,
    output logic                   resp_allow_o,
    output logic                   resp_err_o,
    output logic [ADDR_W-1:0]      ar_addr_o,
    output logic [7:0]             ar_len_o,
    output logic                   ar_valid_o,
    input  logic                   ar_ready_i,
    input  logic [BLK_BYTES*8-1:0] r_data_i,
    input  logic [1:0]             r_resp_i,
    input  logic                   r_last_i,
    input  logic                   r_valid_i,
    output logic                   r_ready_o
);

    localparam int EPB    = BLK_BYTES / ENTRY_BYTES;
    localparam int EPB_LG = clogb2(EPB);
    localparam int SEL_W  = (EPB_LG > 0) ? EPB_LG : 1;
    localparam int BLK_LG = clogb2(BLK_BYTES);
    localparam int CH_W   = (NUM_CH > 1) ? clogb2(NUM_CH) : 1;
    localparam int NWORD  = BLK_BYTES / 8;
    localparam int EBITS  = ENTRY_BYTES * 8;

    localparam att_lkup_rsp_t RANGE_ERR_RSP = '{ppa: '0, sts: STS_DALLOC, zpd_cnt: '0,
                                                allow: 1'b0, err: 1'b1};

    att_lkup_st_e        r_state, w_state_next;
    logic [CH_W-1:0]     r_ch;
    logic [SEL_W-1:0]    r_sel;
    logic [ADDR_W-1:0]   r_ar_addr;
    att_lkup_rsp_t       r_rsp;
    logic                r_first;

    logic                w_in_idle, w_grant, w_oor, w_beat;
    logic [NUM_CH-1:0]   w_gnt;
    logic [CH_W-1:0]     w_gnt_idx;
    logic [PN_W-1:0]     w_hppa, w_idx;
    logic [ADDR_W-1:0]   w_ar_addr;
    logic [BLK_BYTES*8-1:0] w_data;
    logic [63:0]         w_entries [EPB];
    AttEntry             w_entry;
    att_lkup_rsp_t       w_beat_rsp;
    logic                w_unused_ppa;

    assign w_in_idle = (r_state == ST_IDLE) && rst_ni;

    hawk_rr_arb #(.N(NUM_CH)) u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (w_in_idle),
        .req_i     (req_valid_i),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    assign w_grant   = |w_gnt;
    assign w_hppa    = req_hppa_i[int'(w_gnt_idx)*PN_W +: PN_W];
    // Modular subtraction: hppa below the base wraps to a huge index and is caught as out of range
    assign w_idx     = w_hppa - PN_W'(HPPA_BASE >> 12);
    assign w_oor     = ADDR_W'(w_idx) >= ADDR_W'(ATT_ENTRIES);
    assign w_ar_addr = ATT_BASE + (ADDR_W'(w_idx >> EPB_LG) << BLK_LG);

    for (genvar gi = 0; gi < NWORD; gi++) begin : g_swap
        if (BYTESWAP != 0) begin : g_on
            assign w_data[gi*64 +: 64] = get_8byte_byteswap(r_data_i[gi*64 +: 64]);
        end else begin : g_off
            assign w_data[gi*64 +: 64] = r_data_i[gi*64 +: 64];
        end
    end

    for (genvar gi = 0; gi < EPB; gi++) begin : g_ent
        assign w_entries[gi] = w_data[gi*EBITS +: 64];
    end

    assign w_entry = AttEntry'(w_entries[r_sel]);
    assign w_beat  = (r_state == ST_R) && r_valid_i;

    always_comb begin
        w_beat_rsp         = '0;
        w_beat_rsp.ppa     = w_entry.way;
        w_beat_rsp.sts     = w_entry.sts;
        w_beat_rsp.zpd_cnt = w_entry.zpd_cnt;
        w_beat_rsp.err     = (r_resp_i != 2'b00);
        w_beat_rsp.allow   = (w_entry.sts != STS_DALLOC) && (r_resp_i == 2'b00);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant)                w_state_next = w_oor ? ST_RESP : ST_AR;
            ST_AR:   if (ar_ready_i)             w_state_next = ST_R;
            ST_R:    if (r_valid_i && r_last_i)  w_state_next = ST_RESP;
            ST_RESP: if (resp_ready_i[r_ch])     w_state_next = ST_IDLE;
            default:                             w_state_next = ST_IDLE;
        endcase
    end

    // Only the first R beat is decoded; later beats of a burst are drained
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ch      <= '0;
            r_sel     <= '0;
            r_ar_addr <= '0;
            r_rsp     <= '0;
            r_first   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ch      <= w_gnt_idx;
                r_sel     <= w_idx[SEL_W-1:0];
                r_ar_addr <= w_ar_addr;
                r_first   <= 1'b1;
                r_rsp     <= w_oor ? RANGE_ERR_RSP : '0;
            end
            if (w_beat && r_first) begin
                r_rsp   <= w_beat_rsp;
                r_first <= 1'b0;
            end
        end
    end

    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        resp_ppa_o   = '0;
        resp_sts_o   = '0;
        resp_zpd_o   = '0;
        resp_allow_o = 1'b0;
        resp_err_o   = 1'b0;
        ar_addr_o    = '0;
        ar_valid_o   = 1'b0;
        r_ready_o    = 1'b0;
        if (w_in_idle) req_ready_o = w_gnt;
        case (r_state)
            ST_AR: begin
                ar_valid_o = 1'b1;
                ar_addr_o  = r_ar_addr;
            end
            ST_R: r_ready_o = 1'b1;
            ST_RESP: begin
                resp_valid_o = NUM_CH'(1) << r_ch;
                resp_ppa_o   = r_rsp.ppa[PN_W-1:0];
                resp_sts_o   = r_rsp.sts;
                resp_zpd_o   = r_rsp.zpd_cnt;
                resp_allow_o = r_rsp.allow;
                resp_err_o   = r_rsp.err;
            end
            default: ;
        endcase
    end

    assign ar_len_o     = 8'd0;
    assign w_unused_ppa = ^r_rsp.ppa;

endmodule

// File: tb/tb_hawk_att_lkup_arb.sv
// Randomised bench: two DUTs (BYTESWAP 0 and 1) run in lock-step against a table-driven ATT model.
module tb_hawk_att_lkup_arb;
    import hacd_pkg::*;

    localparam int          NUM_CH  = 2;
    localparam int          ADDR_W  = 64;
    localparam int          PN_W    = 52;
    localparam int          ENTRIES = 64;
    localparam int          BLK     = 64;
    localparam int          EPB     = 8;
    localparam logic [63:0] ATT_B   = 64'h0000_0000_1000_0000;
    localparam logic [63:0] HPPA_B  = 64'h0000_0000_8000_0000;
    localparam logic [PN_W-1:0] BASE_PN = HPPA_B[63:12];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [NUM_CH-1:0]      req_valid;
    logic [NUM_CH*PN_W-1:0] req_hppa;
    logic [NUM_CH-1:0]      resp_ready;
    logic                   ar_ready;
    logic [1:0]             r_resp;
    logic                   r_last, r_valid;
    logic [BLK*8-1:0]       r_data     [2];
    logic [NUM_CH-1:0]      req_ready  [2];
    logic [NUM_CH-1:0]      resp_valid [2];
    logic [PN_W-1:0]        resp_ppa   [2];
    logic [1:0]             resp_sts   [2];
    logic [7:0]             resp_zpd   [2];
    logic                   resp_allow [2];
    logic                   resp_err   [2];
    logic [ADDR_W-1:0]      ar_addr    [2];
    logic [7:0]             ar_len     [2];
    logic                   ar_valid   [2];
    logic                   r_ready    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        hawk_att_lkup_arb #(
            .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PN_W(PN_W), .ATT_BASE(ATT_B),
            .HPPA_BASE(HPPA_B), .ATT_ENTRIES(ENTRIES), .BLK_BYTES(BLK),
            .ENTRY_BYTES(8), .BYTESWAP(gi)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .req_valid_i(req_valid), .req_hppa_i(req_hppa), .req_ready_o(req_ready[gi]),
            .resp_valid_o(resp_valid[gi]), .resp_ready_i(resp_ready),
            .resp_ppa_o(resp_ppa[gi]), .resp_sts_o(resp_sts[gi]), .resp_zpd_o(resp_zpd[gi]),
            .resp_allow_o(resp_allow[gi]), .resp_err_o(resp_err[gi]),
            .ar_addr_o(ar_addr[gi]), .ar_len_o(ar_len[gi]), .ar_valid_o(ar_valid[gi]),
            .ar_ready_i(ar_ready), .r_data_i(r_data[gi]), .r_resp_i(r_resp),
            .r_last_i(r_last), .r_valid_i(r_valid), .r_ready_o(r_ready[gi])
        );
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          n_txn = 0;
    int          model_rr;
    logic [63:0] att_mem [ENTRIES];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bswap(input logic [63:0] w);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = w[(7-b)*8 +: 8];
        return r;
    endfunction

    function automatic logic [BLK*8-1:0] line_of(input int line, input int swap);
        logic [BLK*8-1:0] d;
        for (int k = 0; k < EPB; k++)
            d[k*64 +: 64] = (swap != 0) ? bswap(att_mem[line*EPB+k]) : att_mem[line*EPB+k];
        return d;
    endfunction

    function automatic int pick(input logic [NUM_CH-1:0] v);
        for (int k = 0; k < NUM_CH; k++)
            if (v[(model_rr + k) % NUM_CH]) return (model_rr + k) % NUM_CH;
        return -1;
    endfunction

    function automatic logic [PN_W-1:0] rand_hppa();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE_PN + PN_W'(ENTRIES + $urandom_range(0, 100));
        if (r == 1) return BASE_PN - PN_W'(1 + $urandom_range(0, 5));
        return BASE_PN + PN_W'($urandom_range(0, ENTRIES-1));
    endfunction

    task automatic check_idle(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_araddr%0d", tag, u), ar_addr[u], 0);
            chk($sformatf("%s_ppa%0d", tag, u), 64'(resp_ppa[u]), 0);
            chk($sformatf("%s_ctl%0d", tag, u),
                64'({req_ready[u], resp_valid[u], resp_sts[u], resp_zpd[u], resp_allow[u],
                     resp_err[u], ar_len[u], ar_valid[u], r_ready[u]}), 0);
        end
    endtask

    task automatic run_txn(input logic [NUM_CH-1:0] vmask, input logic [PN_W-1:0] h0,
                           input logic [PN_W-1:0] h1, input int ar_dly, input int r_gap,
                           input int extra, input logic [1:0] rresp, input int rsp_dly,
                           input bit abort_r);
        int                ch, line;
        logic [PN_W-1:0]   idx;
        bit                oor;
        logic [63:0]       ent, exp_addr;
        logic [NUM_CH-1:0] oh;
        logic [PN_W-1:0]   e_ppa;
        logic [1:0]        e_sts;
        logic [7:0]        e_zpd;
        bit                e_err, e_allow;

        @(negedge clk);
        req_valid = vmask;
        req_hppa  = {h1, h0};
        #1;
        ch = pick(vmask);
        oh = NUM_CH'(1) << ch;
        for (int u = 0; u < 2; u++) chk($sformatf("grant%0d", u), 64'(req_ready[u]), 64'(oh));
        model_rr = (ch + 1) % NUM_CH;
        idx      = ((ch == 0) ? h0 : h1) - BASE_PN;
        oor      = (64'(idx) >= 64'(ENTRIES));
        line     = oor ? 0 : int'(idx) / EPB;
        exp_addr = ATT_B + 64'(line * BLK);
        ent      = oor ? 64'd0 : att_mem[int'(idx)];
        e_ppa    = PN_W'(ent >> 2);
        e_sts    = ent[1:0];
        e_zpd    = ent[63:56];
        e_err    = oor || (rresp != 2'b00);
        e_allow  = (e_sts != 2'b00) && !e_err;
        @(negedge clk);

        if (!oor) begin
            for (int i = 0; i <= ar_dly; i++) begin
                for (int u = 0; u < 2; u++) begin
                    chk($sformatf("arvalid%0d", u), 64'(ar_valid[u]), 1);
                    chk($sformatf("araddr%0d", u), ar_addr[u], exp_addr);
                    chk($sformatf("nogrant_ar%0d", u), 64'({req_ready[u], resp_valid[u]}), 0);
                end
                if (i == ar_dly) ar_ready = 1'b1;
                @(negedge clk);
            end
            ar_ready = 1'b0;
            if (abort_r) begin
                rst_n     = 1'b0;
                req_valid = '0;
                @(negedge clk);
                check_idle("abort");
                rst_n    = 1'b1;
                model_rr = 0;
                $display("txn %0d ch=%0d idx=%0d aborted by reset in R", n_txn, ch, idx);
                n_txn++;
                return;
            end
            for (int i = 0; i < r_gap; i++) begin
                for (int u = 0; u < 2; u++) chk($sformatf("rready_gap%0d", u), 64'({ar_valid[u], r_ready[u]}), 1);
                @(negedge clk);
            end
            r_valid   = 1'b1;
            r_resp    = rresp;
            r_last    = (extra == 0);
            r_data[0] = line_of(line, 0);
            r_data[1] = line_of(line, 1);
            for (int u = 0; u < 2; u++) chk($sformatf("rready%0d", u), 64'(r_ready[u]), 1);
            @(negedge clk);
            for (int i = 0; i < extra; i++) begin
                r_resp    = 2'b00;
                r_data[0] = {16{$urandom()}};
                r_data[1] = {16{$urandom()}};
                r_last    = (i == extra - 1);
                for (int u = 0; u < 2; u++)
                    chk($sformatf("drain%0d", u), 64'({r_ready[u], resp_valid[u]}), 64'({1'b1, {NUM_CH{1'b0}}}));
                @(negedge clk);
            end
            r_valid = 1'b0;
            r_last  = 1'b0;
        end

        for (int i = 0; i <= rsp_dly; i++) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("respvalid%0d", u), 64'(resp_valid[u]), 64'(oh));
                chk($sformatf("ppa%0d", u), 64'(resp_ppa[u]), 64'(e_ppa));
                chk($sformatf("sts_zpd_allow_err%0d", u),
                    64'({resp_sts[u], resp_zpd[u], resp_allow[u], resp_err[u]}),
                    64'({e_sts, e_zpd, e_allow, e_err}));
                chk($sformatf("quiet_resp%0d", u), 64'({req_ready[u], ar_valid[u]}), 0);
            end
            resp_ready = (i == rsp_dly) ? {NUM_CH{1'b1}} : ~oh;
            @(negedge clk);
        end
        resp_ready = '0;
        req_valid  = '0;
        #1;
        check_idle("post");
        $display("txn %0d ch=%0d idx=%0h oor=%0d err=%0d allow=%0d", n_txn, ch, idx, oor, e_err, e_allow);
        n_txn++;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_hppa   = '0;
        resp_ready = '0;
        ar_ready   = 1'b0;
        r_resp     = 2'b00;
        r_last     = 1'b0;
        r_valid    = 1'b0;
        r_data[0]  = '0;
        r_data[1]  = '0;
        model_rr   = 0;
        for (int i = 0; i < ENTRIES; i++) att_mem[i] = {$urandom(), $urandom()};
        att_mem[10] = {8'h05, 54'h1234, 2'b10};
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        run_txn(2'b01, BASE_PN + PN_W'(10), BASE_PN + PN_W'(3), 0, 0, 0, 2'b00, 0, 0);
        run_txn(2'b10, BASE_PN + PN_W'(1), BASE_PN + PN_W'(2), 0, 0, 0, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++)
            run_txn(2'b11, BASE_PN + PN_W'(i), BASE_PN + PN_W'(20 + i), 0, 0, 0, 2'b00, 0, 0);
        run_txn(2'b01, BASE_PN + PN_W'(ENTRIES), '0, 0, 0, 0, 2'b00, 0, 0);
        run_txn(2'b10, '0, BASE_PN + PN_W'(ENTRIES - 1), 0, 0, 0, 2'b00, 0, 0);
        run_txn(2'b01, BASE_PN + PN_W'(10), '0, 0, 0, 1, 2'b10, 0, 0);
        run_txn(2'b11, BASE_PN + PN_W'(33), BASE_PN + PN_W'(10), 20, 0, 0, 2'b00, 5, 0);
        run_txn(2'b11, BASE_PN + PN_W'(17), BASE_PN + PN_W'(40), 1, 0, 0, 2'b00, 0, 1);
        run_txn(2'b11, BASE_PN + PN_W'(5), BASE_PN + PN_W'(6), 0, 0, 0, 2'b00, 0, 0);

        for (int t = 0; t < 60; t++) begin
            logic [NUM_CH-1:0] vm;
            logic [1:0]        rr;
            vm = NUM_CH'($urandom_range(1, 3));
            rr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(vm, rand_hppa(), rand_hppa(), $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0, rr,
                    $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
